// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flip-flop.
// Computes diff = a - b - borrow_in over WIDTH bits, LSB first, one bit per clock.
// The block uses a start/busy/done handshake. The result registers change only
// when an operation completes.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // The counter must be able to hold WIDTH itself, so WIDTH+1 values are needed.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0]    count;
    logic             borrow_q;

    logic             x, y, d, borrow_nxt, last;
    logic [WIDTH-1:0] r_nxt;

    // Full-subtractor cell on the current LSBs, plus the next result-register value.
    always_comb begin
        x          = a_sh[0];
        y          = b_sh[0];
        d          = x ^ y ^ borrow_q;
        borrow_nxt = (~x & y) | (~(x ^ y) & borrow_q);
        // A shift-and-or form keeps this legal when WIDTH=1, where no slice r_sh[WIDTH-1:1] exists.
        r_nxt      = (r_sh >> 1) | (WIDTH'(d) << (WIDTH - 1));
        last       = (count == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. start is seen only in IDLE; DONE always goes back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs, decoded from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath: load operands on accept, then process one bit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            count      <= '0;
            borrow_q   <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh     <= a;
                    b_sh     <= b;
                    borrow_q <= borrow_in;
                    count    <= '0;
                end
                RUN: begin
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    r_sh     <= r_nxt;
                    borrow_q <= borrow_nxt;
                    count    <= count + CW'(1);
                    // Publish only the completed word so intermediate bits are never visible.
                    if (last) begin
                        diff       <= r_nxt;
                        borrow_out <= borrow_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed bench for serial_full_subtractor: one WIDTH=8 instance and one WIDTH=1 instance.
module tb_serial_full_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start, bin;
    logic [7:0] a, b;
    logic       busy, done, bo;
    logic [7:0] diff;

    // WIDTH=1 instance
    logic       start1, bin1;
    logic [0:0] a1, b1, diff1;
    logic       busy1, done1, bo1;

    int checks = 0;
    int failures = 0;

    serial_full_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(bin),
        .busy(busy), .done(done), .diff(diff), .borrow_out(bo)
    );

    serial_full_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation. It checks busy, latency, result, the hold of the previous
    // result during RUN, and the return to idle. With scramble set, the inputs and start
    // toggle randomly during RUN.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input bit scramble, input logic [7:0] ed, input logic eb,
                       input string tag);
        int         lat;
        logic [7:0] hold_d;
        logic       hold_b;
        hold_d = diff;
        hold_b = bo;
        a = av; b = bv; bin = bi; start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, ".busy"}, busy, 1);
        lat = 0;
        while (!done && lat < 40) begin
            chk({tag, ".hold_d"}, diff, hold_d);
            chk({tag, ".hold_b"}, bo, hold_b);
            if (scramble) begin
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); start = 1'($urandom);
            end
            tick;
            lat++;
        end
        start = 1'b0;
        chk({tag, ".lat"}, lat, 8);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".diff"}, diff, ed);
        chk({tag, ".bo"}, bo, eb);
        tick;
        chk({tag, ".done_clr"}, done, 0);
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".diff_keep"}, diff, ed);
    endtask

    initial begin
        int lat;
        int pulses;
        start = 0; a = '0; b = '0; bin = 0;
        start1 = 0; a1 = '0; b1 = '0; bin1 = 0;

        #12;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.diff", diff, 0);
        chk("rst.bo", bo, 0);
        chk("rst.busy1", busy1, 0);
        rst_n = 1'b1;
        tick;

        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h1E, 1'b0, "basic");
        op8(8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, "under");
        op8(8'h80, 8'h7F, 1'b1, 1'b0, 8'h00, 1'b0, "bin_zero");
        op8(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, "scramble");

        // Hold start high: the second operand pair must not disturb the first operation.
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        tick;
        a = 8'h03; b = 8'h05;
        lat = 0;
        while (!done && lat < 40) begin tick; lat++; end
        chk("held.lat1", lat, 8);
        chk("held.diff1", diff, 8'h0F);
        chk("held.bo1", bo, 0);
        tick;
        chk("held.pulse1", done, 0);
        lat = 0;
        while (!done && lat < 40) begin tick; lat++; end
        chk("held.done2", done, 1);
        chk("held.diff2", diff, 8'hFE);
        chk("held.bo2", bo, 1);
        start = 1'b0;
        tick;
        chk("held.pulse2", done, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin tick; if (done) pulses++; end
        chk("held.no_extra", pulses, 0);

        // Abort with reset while RUN is working on bit 4.
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        chk("abort.busy_pre", busy, 1);
        rst_n = 1'b0;
        #2;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.diff", diff, 0);
        chk("abort.bo", bo, 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin tick; if (done) pulses++; end
        chk("abort.no_done", pulses, 0);
        op8(8'h20, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, "post_abort");

        // WIDTH=1 truth table, computed as an integer difference.
        for (int i = 0; i < 8; i++) begin
            int   v;
            logic x, y, z;
            x = i[2]; y = i[1]; z = i[0];
            v = int'(x) - int'(y) - int'(z);
            a1 = x; b1 = y; bin1 = z; start1 = 1'b1;
            tick;
            start1 = 1'b0;
            chk($sformatf("w1.%0d.busy", i), busy1, 1);
            chk($sformatf("w1.%0d.early", i), done1, 0);
            tick;
            chk($sformatf("w1.%0d.done", i), done1, 1);
            chk($sformatf("w1.%0d.diff", i), diff1, v & 1);
            chk($sformatf("w1.%0d.bo", i), bo1, (v < 0) ? 1 : 0);
            tick;
            chk($sformatf("w1.%0d.idle", i), busy1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
